// File: rtl/eeprom_pkg.sv
// Shared widths, opcodes, error codes and FSM encoding for the EEPROM port arbiter.
package eeprom_pkg;

    localparam int DEV_W  = 3;
    localparam int ADDR_W = 16;
    localparam int TYPE_W = 2;
    localparam int LEN_W  = 8;
    localparam int DATA_W = 8;

    localparam logic [TYPE_W-1:0] OP_WRITE = 2'd1;
    localparam logic [TYPE_W-1:0] OP_READ  = 2'd2;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_BUSY,
        ST_DRAIN,
        ST_REJECT
    } state_t;

    function automatic logic type_legal(input logic [TYPE_W-1:0] t);
        return (t == OP_WRITE) || (t == OP_READ);
    endfunction

endpackage

// File: rtl/eeprom_arbiter_rr.sv
// Combinational round-robin picker: first set request after last_i, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      last_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic               any_o
);

    logic          found;
    logic [IW-1:0] idx;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = '0;
        any_o   = |req_i;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = IW'((int'(last_i) + i) % NUM_REQ);
            if (!found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/eeprom_arbiter.sv
// Round-robin owner of the single eeprom_ctrl port; one whole transaction per grant.
// Command/stream/read paths are zero-latency muxes; the grant is held through a drain window.
module eeprom_arbiter
    import eeprom_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int DRAIN_CYC   = 2,
    parameter int TIMEOUT_CYC = 2000000
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [DEV_W*NUM_REQ-1:0]   i_req_eeprom_addr,
    input  logic [ADDR_W*NUM_REQ-1:0]  i_req_operation_addr,
    input  logic [TYPE_W*NUM_REQ-1:0]  i_req_operation_type,
    input  logic [LEN_W*NUM_REQ-1:0]   i_req_operation_len,
    input  logic [NUM_REQ-1:0]         i_req_operation_valid,
    output logic [NUM_REQ-1:0]         o_req_operation_ready,
    input  logic [DATA_W*NUM_REQ-1:0]  i_req_write_data,
    input  logic [NUM_REQ-1:0]         i_req_write_sop,
    input  logic [NUM_REQ-1:0]         i_req_write_eop,
    input  logic [NUM_REQ-1:0]         i_req_write_valid,
    output logic [DATA_W-1:0]          o_req_read_data,
    output logic [NUM_REQ-1:0]         o_req_read_valid,
    output logic [NUM_REQ-1:0]         o_req_busy,
    output logic                       o_err,
    output logic [1:0]                 o_err_code,
    output logic [DEV_W-1:0]           o_ctrl_eeprom_addr,
    output logic [ADDR_W-1:0]          o_ctrl_operation_addr,
    output logic [TYPE_W-1:0]          o_ctrl_operation_type,
    output logic [LEN_W-1:0]           o_ctrl_operation_len,
    output logic                       o_ctrl_operation_valid,
    input  logic                       i_ctrl_operation_ready,
    output logic [DATA_W-1:0]          o_ctrl_write_data,
    output logic                       o_ctrl_write_sop,
    output logic                       o_ctrl_write_eop,
    output logic                       o_ctrl_write_valid,
    input  logic [DATA_W-1:0]          i_ctrl_read_data,
    input  logic                       i_ctrl_read_valid
);

    localparam int IW         = $clog2(NUM_REQ);
    localparam int TW         = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam int DW         = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC + 1) : 1;
    localparam int DRAIN_LAST = (DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [IW-1:0]        gidx_q, gidx_d;
    logic [IW-1:0]        last_q, last_d;
    logic                 seen_low_q, seen_low_d;
    logic [TW-1:0]        tmo_q, tmo_d;
    logic [DW-1:0]        drain_q, drain_d;

    logic [NUM_REQ-1:0]   rr_grant;
    logic [IW-1:0]        rr_idx;
    logic                 any_req;
    logic                 fwd;
    logic                 owned;
    logic [TYPE_W-1:0]    g_type;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req_i   (i_req_operation_valid),
        .last_i  (last_q),
        .grant_o (rr_grant),
        .any_o   (any_req)
    );

    always_comb begin
        rr_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rr_grant[i]) rr_idx = IW'(i);
        end
    end

    assign g_type = i_req_operation_type[gidx_q*TYPE_W +: TYPE_W];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            gidx_q     <= '0;
            last_q     <= IW'(NUM_REQ - 1);
            seen_low_q <= 1'b0;
            tmo_q      <= '0;
            drain_q    <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            gidx_q     <= gidx_d;
            last_q     <= last_d;
            seen_low_q <= seen_low_d;
            tmo_q      <= tmo_d;
            drain_q    <= drain_d;
        end
    end

    always_comb begin
        state_d                = state_q;
        grant_d                = grant_q;
        gidx_d                 = gidx_q;
        last_d                 = last_q;
        seen_low_d             = seen_low_q;
        tmo_d                  = tmo_q;
        drain_d                = drain_q;
        o_req_operation_ready  = '0;
        o_err                  = 1'b0;
        o_err_code             = ERR_NONE;
        o_ctrl_eeprom_addr     = '0;
        o_ctrl_operation_addr  = '0;
        o_ctrl_operation_type  = '0;
        o_ctrl_operation_len   = '0;
        o_ctrl_operation_valid = 1'b0;
        fwd                    = 1'b0;
        owned                  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    grant_d = rr_grant;
                    gidx_d  = rr_idx;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                fwd                   = 1'b1;
                o_ctrl_eeprom_addr    = i_req_eeprom_addr[gidx_q*DEV_W +: DEV_W];
                o_ctrl_operation_addr = i_req_operation_addr[gidx_q*ADDR_W +: ADDR_W];
                o_ctrl_operation_type = g_type;
                o_ctrl_operation_len  = i_req_operation_len[gidx_q*LEN_W +: LEN_W];
                if (!type_legal(g_type)) begin
                    state_d = ST_REJECT;
                end else begin
                    o_ctrl_operation_valid = 1'b1;
                    if (i_ctrl_operation_ready) begin
                        o_req_operation_ready = grant_q;
                        seen_low_d            = 1'b0;
                        tmo_d                 = '0;
                        state_d               = ST_BUSY;
                    end
                end
            end
            ST_REJECT: begin
                o_req_operation_ready = grant_q;
                o_err                 = 1'b1;
                o_err_code            = ERR_ILLEGAL;
                last_d                = gidx_q;
                state_d               = ST_IDLE;
            end
            ST_BUSY: begin
                fwd   = 1'b1;
                owned = 1'b1;
                tmo_d = tmo_q + TW'(1);
                // Controller ready is still high the cycle after accept; only a
                // rise after it has been seen low marks the end of the operation.
                if (!i_ctrl_operation_ready) seen_low_d = 1'b1;
                if ((TIMEOUT_CYC != 0) && (tmo_q == TW'(TIMEOUT_CYC - 1))) begin
                    o_err      = 1'b1;
                    o_err_code = ERR_TIMEOUT;
                    drain_d    = '0;
                    state_d    = ST_DRAIN;
                end else if (seen_low_q && i_ctrl_operation_ready) begin
                    drain_d = '0;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                fwd     = 1'b1;
                owned   = 1'b1;
                drain_d = drain_q + DW'(1);
                if (drain_q == DW'(DRAIN_LAST)) begin
                    last_d  = gidx_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign o_ctrl_write_data  = fwd ? i_req_write_data[gidx_q*DATA_W +: DATA_W] : '0;
    assign o_ctrl_write_sop   = fwd & i_req_write_sop[gidx_q];
    assign o_ctrl_write_eop   = fwd & i_req_write_eop[gidx_q];
    assign o_ctrl_write_valid = fwd & i_req_write_valid[gidx_q];

    assign o_req_read_data  = i_ctrl_read_data;
    assign o_req_read_valid = owned ? (grant_q & {NUM_REQ{i_ctrl_read_valid}}) : '0;
    assign o_req_busy       = owned ? grant_q : '0;

endmodule

// File: doc/eeprom_arbiter.md
Name: eeprom_arbiter

Overview:
Shares the single EEPROM controller command/data port between NUM_REQ requesters. Example requesters are the boot config loader and the host register bridge. Grants are round-robin, one whole transaction at a time. The arbiter forwards the granted requester's command and write stream, and routes read data back only to that requester. It sits between the requesters and eeprom_ctrl and holds the grant until the controller has fully returned to idle.

Parameters:
NUM_REQ, 2, number of requesters (2..8).
DRAIN_CYC, 2, cycles the grant is held after downstream ready returns, so trailing read beats are captured.
TIMEOUT_CYC, 2000000, maximum BUSY cycles before forced release; 0 disables the timeout.

Ports:
i_clk  in  1  clock
i_rst  in  1  reset
i_req_eeprom_addr  in  3*NUM_REQ  per-requester EEPROM device select
i_req_operation_addr  in  16*NUM_REQ  per-requester byte address
i_req_operation_type  in  2*NUM_REQ  1=write, 2=read
i_req_operation_len  in  8*NUM_REQ  byte count
i_req_operation_valid  in  NUM_REQ  command valid; held stable until ready
o_req_operation_ready  out  NUM_REQ  one-cycle accept strobe
i_req_write_data  in  8*NUM_REQ  write stream data
i_req_write_sop  in  NUM_REQ  write stream start of packet
i_req_write_eop  in  NUM_REQ  write stream end of packet
i_req_write_valid  in  NUM_REQ  write stream valid
o_req_read_data  out  8  read data, shared bus
o_req_read_valid  out  NUM_REQ  read valid, granted requester only
o_req_busy  out  NUM_REQ  transaction owned by this requester is in progress
o_err  out  1  one-cycle pulse on illegal type or timeout
o_err_code  out  2  0 none, 1 illegal type, 2 timeout
o_ctrl_eeprom_addr, o_ctrl_operation_addr, o_ctrl_operation_type, o_ctrl_operation_len  out  3/16/2/8  command to eeprom_ctrl
o_ctrl_operation_valid  out  1  command valid to eeprom_ctrl
i_ctrl_operation_ready  in  1  eeprom_ctrl ready
o_ctrl_write_data, o_ctrl_write_sop, o_ctrl_write_eop, o_ctrl_write_valid  out  8/1/1/1  write stream to eeprom_ctrl
i_ctrl_read_data  in  8  read data from eeprom_ctrl
i_ctrl_read_valid  in  1  read valid from eeprom_ctrl

Behaviour:
- Reset is i_rst, asynchronous, active-high; clock is i_clk.
- Reset values: all outputs 0; internal r_last_grant = NUM_REQ-1, so requester 0 wins first.
- States are IDLE, ISSUE, BUSY, DRAIN, REJECT.
- IDLE:
  - If any valid is set, grant the first set valid searching from r_last_grant+1 with wrap-around.
  - Latch the one-hot grant; go to ISSUE the next cycle.
  - Requests arriving in the same cycle resolve by the round-robin order only.
- ISSUE:
  - o_ctrl_* command fields are a combinational mux of the granted requester's inputs.
  - o_ctrl_operation_valid = 1, unless the granted type is 0 or 3; in that case go to REJECT.
  - On valid & i_ctrl_operation_ready, pulse o_req_operation_ready[grant] in the same cycle and go to BUSY.
- REJECT (1 cycle):
  - Pulse o_req_operation_ready[grant], o_err, and o_err_code=1.
  - Nothing is forwarded downstream. Go to IDLE and update r_last_grant.
- BUSY:
  - First observe i_ctrl_operation_ready = 0. It drops 1 cycle after accept, so a sticky flag is needed.
  - Once the flag is set, a rising ready moves to DRAIN.
  - The timeout counter runs in BUSY. Reaching TIMEOUT_CYC pulses o_err with code 2 and moves to DRAIN.
- DRAIN: counts DRAIN_CYC cycles, then IDLE; r_last_grant = grant.
- Write stream:
  - o_ctrl_write_* = granted requester's stream during ISSUE, BUSY and DRAIN; otherwise 0.
  - Non-granted write_valid is dropped silently.
  - The arbiter adds zero latency (combinational mux).
- Read return:
  - o_req_read_valid[grant] = i_ctrl_read_valid during BUSY and DRAIN; otherwise all bits 0.
  - o_req_read_data = i_ctrl_read_data, unconditionally.
- o_req_busy[grant] = 1 from ISSUE accept to DRAIN exit.
- A requester dropping valid during ISSUE is a protocol violation: the arbiter stays in ISSUE with the mux following the inputs. The bench flags it by assertion.
- Reset mid-transaction returns to IDLE immediately. The eeprom_ctrl is reset by the same i_rst.

Decomposition:
- Package eeprom_pkg holds:
  - operation type constants OP_WRITE=1, OP_READ=2;
  - error codes;
  - state encoding;
  - field widths 3/16/2/8.
- Sub-module rr_arbiter(NUM_REQ): request vector plus last grant in, one-hot grant plus any-request out, purely combinational. Used in IDLE.

Test Plan:
- Req0 write addr 0x0010 len 4, bytes AA BB CC DD -> ctrl sees the command and 4 beats with sop on AA and eop on DD; ready0 pulses once; busy0 high until DRAIN exit.
- Req1 read addr 0x0100 len 3, model returns 11 22 33 -> o_req_read_valid[1] 3 beats with 11,22,33; o_req_read_valid[0] stays 0, including the beat arriving after ctrl ready rises.
- Req0 and req1 valid in the same cycle after reset -> req0 served first, then req1; repeated simultaneous requests alternate 0,1,0,1.
- Req0 type 3 -> ready0 pulse, o_err with code 1, o_ctrl_operation_valid never asserted, next request served normally.
- Model holds ready low forever, TIMEOUT_CYC=100 -> o_err with code 2 at BUSY cycle 100, then IDLE after DRAIN_CYC.
- i_rst asserted in BUSY -> all outputs 0 asynchronously; after release the first grant goes to req0.
